// File: rtl/shift_pipe_if.sv
// Request/response handshake bundle between a producer/consumer and the shift pipeline.
interface shift_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;

  modport master (
    output in_valid, funct, shamt, rs, rt, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, funct, shamt, rs, rt, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/shift_pipe.sv
// Two-stage MIPS shift unit wrapper: decode/issue register feeding an external
// barrel shifter, then a result register with valid/ready backpressure.
module shift_pipe #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  shift_pipe_if.slave      bus,
  output logic [31:0]      sh_a,
  output logic [31:0]      sh_b,
  output logic [1:0]       sh_ctrl,
  input  logic [31:0]      sh_dout,
  output logic [CNT_W-1:0] op_count
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned AMT_W   = 5;
  localparam int unsigned FUNCT_W = 6;

  localparam logic [1:0] CTRL_SLL  = 2'b00;
  localparam logic [1:0] CTRL_SRL  = 2'b01;
  localparam logic [1:0] CTRL_SRA  = 2'b11;
  localparam logic [1:0] CTRL_PASS = 2'b10;

  localparam logic [FUNCT_W-1:0] F_SLL  = 6'b000000;
  localparam logic [FUNCT_W-1:0] F_SRL  = 6'b000010;
  localparam logic [FUNCT_W-1:0] F_SRA  = 6'b000011;
  localparam logic [FUNCT_W-1:0] F_SLLV = 6'b000100;
  localparam logic [FUNCT_W-1:0] F_SRLV = 6'b000110;
  localparam logic [FUNCT_W-1:0] F_SRAV = 6'b000111;

  logic [AMT_W-1:0]  dec_amt;
  logic [1:0]        dec_ctrl;
  logic              dec_err;

  logic              s1_valid;
  logic              s1_err;
  logic [AMT_W-1:0]  s1_amt;
  logic [DATA_W-1:0] s1_b;
  logic [1:0]        s1_ctrl;

  logic              s2_valid;
  logic              s2_err;
  logic [DATA_W-1:0] s2_data;
  logic [CNT_W-1:0]  count_q;

  logic              accept;
  logic              s2_load;
  logic              move;
  logic              consume;
  logic              unused_rs_hi;

  // Funct decode; illegal opcodes become a zero-amount pass-through flagged as error.
  always_comb begin
    dec_ctrl = CTRL_PASS;
    dec_err  = 1'b1;
    dec_amt  = '0;
    case (bus.funct)
      F_SLL, F_SLLV: begin dec_ctrl = CTRL_SLL; dec_err = 1'b0; end
      F_SRL, F_SRLV: begin dec_ctrl = CTRL_SRL; dec_err = 1'b0; end
      F_SRA, F_SRAV: begin dec_ctrl = CTRL_SRA; dec_err = 1'b0; end
      default:       ;
    endcase
    if (!dec_err) begin
      dec_amt = bus.funct[2] ? bus.rs[AMT_W-1:0] : bus.shamt;
    end
  end

  // Upper rs bits never influence the shift amount.
  assign unused_rs_hi = ^bus.rs[DATA_W-1:AMT_W];

  assign s2_load      = !s2_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || s2_load;
  assign accept       = bus.in_valid && bus.in_ready;
  assign move         = s1_valid && s2_load;
  assign consume      = s2_valid && bus.out_ready;

  // Issue register: operands here drive the shifter directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_amt   <= '0;
      s1_b     <= '0;
      s1_ctrl  <= CTRL_SLL;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_err   <= dec_err;
      s1_amt   <= dec_amt;
      s1_b     <= bus.rt;
      s1_ctrl  <= dec_ctrl;
    end else if (move) begin
      s1_valid <= 1'b0;
    end
  end

  // Result register: captures the shifter output when S1 advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_err   <= 1'b0;
      s2_data  <= '0;
    end else if (move) begin
      s2_valid <= 1'b1;
      s2_err   <= s1_err;
      s2_data  <= sh_dout;
    end else if (consume) begin
      s2_valid <= 1'b0;
    end
  end

  // Completed-operation counter, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (consume) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign sh_a          = DATA_W'(s1_amt);
  assign sh_b          = s1_b;
  assign sh_ctrl       = s1_ctrl;
  assign bus.out_valid = s2_valid;
  assign bus.out_data  = s2_data;
  assign bus.out_err   = s2_err;
  assign op_count      = count_q;

endmodule
